dct_coeff_sequencer: RTL and testbench

//  Computes one 8x8 2D-DCT coefficient X(k1,k2) = sum over n1,n2 of pix[n1][n2]*cos_term(k1,k2,n1,n2).

---
 rtl/dct_pkg.sv | 22 ++
 rtl/dct_coeff_sequencer_if.sv | 52 +++++
 rtl/dct_mac_unit.sv | 75 +++++++
 rtl/dct_coeff_sequencer.sv | 124 ++++++++++++
 tb/tb_dct_coeff_sequencer.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/dct_pkg.sv
// Shared constants and FSM state type for the DCT coefficient sequencer.
// Imported by the interface, the MAC unit and the sequencer top.
package dct_pkg;

   localparam int N          = 8;
   localparam int LOG2N      = 3;
   localparam int ADDR_W     = 2 * LOG2N;
   localparam int COS_FRAC   = 8;
   localparam int PIX_OFFSET = 128;
   localparam int PIX_W      = 8;
   localparam int COS_W      = 32;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N * N - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      OUT
   } dct_seq_state_t;

endpackage

// File: rtl/dct_coeff_sequencer_if.sv
// Bus bundle between the sequencer and its environment.
// Groups the start handshake, the pixel RAM port, the cos LUT selection and the coeff output handshake.
//   slave  : the sequencer side (accepts start, drives RAM/LUT selects and coeff)
//   master : the environment side (issues start, returns pixel/cos data, accepts coeff)
interface dct_coeff_sequencer_if
   import dct_pkg::*;
#(
   parameter int ACC_W = 32
) ();

   logic                    start;
   logic [LOG2N-1:0]        start_k1;
   logic [LOG2N-1:0]        start_k2;
   logic                    start_ready;

   logic                    pix_re;
   logic [ADDR_W-1:0]       pix_addr;
   logic [PIX_W-1:0]        pix_rdata;

   logic [LOG2N-1:0]        lut_k1;
   logic [LOG2N-1:0]        lut_k2;
   logic [LOG2N-1:0]        lut_n1;
   logic [LOG2N-1:0]        lut_n2;
   logic signed [COS_W-1:0] cos_term;

   logic                    coeff_valid;
   logic                    coeff_ready;
   logic signed [ACC_W-1:0] coeff;

   modport slave (
      input  start, start_k1, start_k2,
      output start_ready,
      output pix_re, pix_addr,
      input  pix_rdata,
      output lut_k1, lut_k2, lut_n1, lut_n2,
      input  cos_term,
      output coeff_valid, coeff,
      input  coeff_ready
   );

   modport master (
      output start, start_k1, start_k2,
      input  start_ready,
      input  pix_re, pix_addr,
      output pix_rdata,
      input  lut_k1, lut_k2, lut_n1, lut_n2,
      output cos_term,
      input  coeff_valid, coeff,
      output coeff_ready
   );

endinterface

// File: rtl/dct_mac_unit.sv
// Level shift, signed multiply, accumulate and Q-rounding for one DCT coefficient.
// Ports: clk/rst; clear zeroes acc; mac_v adds pix*cos; load registers the rounded sum into coeff.
module dct_mac_unit
   import dct_pkg::*;
#(
   parameter int ACC_W       = 32,
   parameter int FRAC        = COS_FRAC,
   parameter bit LEVEL_SHIFT = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clear,
   input  logic                    mac_v,
   input  logic [PIX_W-1:0]        pix,
   input  logic signed [COS_W-1:0] cos_term,
   input  logic                    load,
   output logic signed [ACC_W-1:0] coeff
);

   localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(2 ** (FRAC - 1));

   logic signed [PIX_W:0]   px;
   logic signed [ACC_W-1:0] px_ext;
   logic signed [ACC_W-1:0] cos_ext;
   logic signed [ACC_W-1:0] prod;
   logic signed [ACC_W-1:0] rnd_sum;
   logic signed [ACC_W-1:0] rnd;

   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic signed [ACC_W-1:0] coeff_q, coeff_d;

   always_comb begin
      if (LEVEL_SHIFT) begin
         px = $signed({1'b0, pix}) - (PIX_W + 1)'(PIX_OFFSET);
      end else begin
         px = $signed({1'b0, pix});
      end
      px_ext  = ACC_W'(px);
      cos_ext = ACC_W'(cos_term);
      // product kept at ACC_W bits; the sum of 64 terms stays well inside 2^22
      prod    = px_ext * cos_ext;
   end

   always_comb begin
      acc_d = acc_q;
      if (clear) begin
         acc_d = '0;
      end else if (mac_v) begin
         acc_d = acc_q + prod;
      end
   end

   // round from acc_d so the final product lands in the same cycle as the load
   always_comb begin
      rnd_sum = acc_d + RND_HALF;
      rnd     = rnd_sum >>> FRAC;
      coeff_d = coeff_q;
      if (load) begin
         coeff_d = rnd;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q   <= '0;
         coeff_q <= '0;
      end else begin
         acc_q   <= acc_d;
         coeff_q <= coeff_d;
      end
   end

   assign coeff = coeff_q;

endmodule

// File: rtl/dct_coeff_sequencer.sv
// Computes one 8x8 2D-DCT coefficient by walking the block buffer and accumulating pix*cos.
// Ports: clk, rst (async, active-high), bus (slave view: start handshake, pixel RAM, LUT select, coeff out).
module dct_coeff_sequencer
   import dct_pkg::*;
#(
   parameter int ACC_W       = 32,
   parameter int FRAC        = COS_FRAC,
   parameter bit LEVEL_SHIFT = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   dct_coeff_sequencer_if.slave  bus
);

   dct_seq_state_t state_q, state_d;

   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [LOG2N-1:0]  k1_q, k1_d;
   logic [LOG2N-1:0]  k2_q, k2_d;
   logic [LOG2N-1:0]  n1_q, n1_d;
   logic [LOG2N-1:0]  n2_q, n2_d;
   logic              mac_v_q, mac_v_d;

   logic              pix_re;
   logic              start_ready;
   logic              acc_clear;
   logic              coeff_load;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      k1_d        = k1_q;
      k2_d        = k2_q;
      pix_re      = 1'b0;
      start_ready = 1'b0;
      acc_clear   = 1'b0;
      coeff_load  = 1'b0;
      unique case (state_q)
         IDLE: begin
            start_ready = 1'b1;
            if (bus.start) begin
               k1_d      = bus.start_k1;
               k2_d      = bus.start_k2;
               idx_d     = '0;
               acc_clear = 1'b1;
               state_d   = RUN;
            end
         end
         RUN: begin
            pix_re = 1'b1;
            if (idx_q == LAST_ADDR) begin
               idx_d   = '0;
               state_d = DRAIN;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DRAIN: begin
            coeff_load = 1'b1;
            state_d    = OUT;
         end
         OUT: begin
            if (bus.coeff_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // LUT row/col follow the RAM address by one cycle so cos_term lines up with pix_rdata
   always_comb begin
      mac_v_d = pix_re;
      n1_d    = idx_q[ADDR_W-1:LOG2N];
      n2_d    = idx_q[LOG2N-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         k1_q    <= '0;
         k2_q    <= '0;
         n1_q    <= '0;
         n2_q    <= '0;
         mac_v_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         k1_q    <= k1_d;
         k2_q    <= k2_d;
         n1_q    <= n1_d;
         n2_q    <= n2_d;
         mac_v_q <= mac_v_d;
      end
   end

   dct_mac_unit #(
      .ACC_W       (ACC_W),
      .FRAC        (FRAC),
      .LEVEL_SHIFT (LEVEL_SHIFT)
   ) u_mac (
      .clk      (clk),
      .rst      (rst),
      .clear    (acc_clear),
      .mac_v    (mac_v_q),
      .pix      (bus.pix_rdata),
      .cos_term (bus.cos_term),
      .load     (coeff_load),
      .coeff    (bus.coeff)
   );

   assign bus.start_ready = start_ready;
   assign bus.pix_re      = pix_re;
   assign bus.pix_addr    = idx_q;
   assign bus.lut_k1      = k1_q;
   assign bus.lut_k2      = k2_q;
   assign bus.lut_n1      = n1_q;
   assign bus.lut_n2      = n2_q;
   assign bus.coeff_valid = (state_q == OUT);

endmodule

// File: tb/tb_dct_coeff_sequencer.sv
// Directed bench for dct_coeff_sequencer: pixel RAM and cos LUT models, hand-computed coefficients.
// Checks latency, LUT index alignment, output hold under backpressure and mid-run reset.
module tb_dct_coeff_sequencer;
   import dct_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int n_chk  = 0;
   int n_pass = 0;

   logic [7:0] mem [64];

   dct_coeff_sequencer_if #(.ACC_W(32)) bus ();

   dct_coeff_sequencer #(
      .ACC_W       (32),
      .FRAC        (8),
      .LEVEL_SHIFT (1'b1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.pix_re) bus.pix_rdata <= mem[bus.pix_addr];
   end

   function automatic logic signed [31:0] cos_fn(input logic [2:0] k1, input logic [2:0] k2,
                                                 input logic [2:0] n1);
      if (k1 == 3'd0 && k2 == 3'd0) return 32'sd256;
      if (k1 == 3'd5 && k2 == 3'd0) begin
         case (n1)
            3'd0: return 32'sd142;
            3'd1: return -32'sd251;
            3'd2: return 32'sd49;
            3'd3: return 32'sd212;
            3'd4: return -32'sd212;
            3'd5: return -32'sd49;
            3'd6: return 32'sd251;
            default: return -32'sd142;
         endcase
      end
      return 32'sd0;
   endfunction

   assign bus.cos_term = cos_fn(bus.lut_k1, bus.lut_k2, bus.lut_n1);

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic fill(input int mode);
      for (int a = 0; a < 64; a++) begin
         case (mode)
            0: mem[a] = 8'd128;
            1: mem[a] = 8'd255;
            2: mem[a] = 8'd200;
            default: mem[a] = 8'(128 + 16 * (a / 8));
         endcase
      end
   endtask

   task automatic do_start(input logic [2:0] k1, input logic [2:0] k2, input string tag);
      @(negedge clk);
      chk({tag, "_start_ready"}, bus.start_ready, 1);
      bus.start    = 1'b1;
      bus.start_k1 = k1;
      bus.start_k2 = k2;
      @(posedge clk);
      #1 bus.start = 1'b0;
   endtask

   // counts negedges after the accept edge until coeff_valid; checks LUT lag
   task automatic wait_valid(input string tag, output int n);
      int          lag_err;
      logic [5:0]  prev;
      n       = 0;
      lag_err = 0;
      prev    = bus.pix_addr;
      while (n < 200) begin
         @(negedge clk);
         n++;
         if (n >= 2 && {bus.lut_n1, bus.lut_n2} != prev) lag_err++;
         prev = bus.pix_addr;
         if (bus.coeff_valid) break;
      end
      chk({tag, "_lut_lag_errs"}, lag_err, 0);
   endtask

   task automatic run(input logic [2:0] k1, input logic [2:0] k2, input longint exp,
                      input string tag);
      int n;
      do_start(k1, k2, tag);
      wait_valid(tag, n);
      chk({tag, "_latency"}, n, 66);
      chk({tag, "_coeff"}, longint'(bus.coeff), exp);
      @(negedge clk);
      chk({tag, "_valid_drop"}, bus.coeff_valid, 0);
   endtask

   initial begin
      int n;
      int hold_err;
      int bound;
      longint c0;
      bus.start       = 1'b0;
      bus.start_k1    = '0;
      bus.start_k2    = '0;
      bus.coeff_ready = 1'b1;
      fill(0);
      #23;
      chk("rst_start_ready", bus.start_ready, 1);
      chk("rst_pix_re", bus.pix_re, 0);
      chk("rst_coeff_valid", bus.coeff_valid, 0);
      chk("rst_coeff", longint'(bus.coeff), 0);
      @(negedge clk);
      rst = 1'b0;

      fill(0); run(3'd0, 3'd0, 0, "t1_flat128");
      fill(1); run(3'd0, 3'd0, 8128, "t2_flat255");
      fill(2); run(3'd5, 3'd0, 0, "t3_uniform_k50");
      fill(3); run(3'd5, 3'd0, -49, "t4_ramp_k50");

      // backpressure: hold 5 cycles, pulse start while holding
      bus.coeff_ready = 1'b0;
      do_start(3'd5, 3'd0, "t5");
      wait_valid("t5", n);
      chk("t5_latency", n, 66);
      c0       = longint'(bus.coeff);
      chk("t5_coeff", c0, -49);
      hold_err = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.start = (i == 1);
         if (longint'(bus.coeff) != c0 || !bus.coeff_valid || bus.start_ready) hold_err++;
      end
      chk("t5_hold_errs", hold_err, 0);
      bus.start       = 1'b1;
      bus.coeff_ready = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("t5_valid_after_hs", bus.coeff_valid, 0);
      chk("t5_start_ready_after_hs", bus.start_ready, 1);
      chk("t5_no_launch", bus.pix_re, 0);

      // reset mid-run at address 30
      fill(1);
      do_start(3'd5, 3'd0, "t6");
      bound = 0;
      while (bus.pix_addr != 6'd30 && bound < 100) begin
         @(negedge clk);
         bound++;
      end
      chk("t6_reached_addr30", bus.pix_addr, 30);
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_pix_re", bus.pix_re, 0);
      chk("t6_rst_pix_addr", bus.pix_addr, 0);
      chk("t6_rst_start_ready", bus.start_ready, 1);
      chk("t6_rst_lut_k1", bus.lut_k1, 0);
      chk("t6_rst_lut_n1", bus.lut_n1, 0);
      chk("t6_rst_valid", bus.coeff_valid, 0);
      chk("t6_rst_coeff", longint'(bus.coeff), 0);
      @(negedge clk);
      rst = 1'b0;
      run(3'd0, 3'd0, 8128, "t6_after_rst");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
